// File: rtl/pipeline_pkg.sv
// +----------------------------------------------------------------------------+
// | pipeline_pkg : shared widths, MEM-stage FSM encoding and the pipeline      |
// |                register field bundles.                                     |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_WAIT = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic                  memRead;
    logic                  memWrite;
    logic                  regWrite;
    logic                  memToReg;
    logic [REG_ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     wdata;
  } exmem_t;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memToReg;
    logic [REG_ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0]     aluOutput;
    logic [DATA_W-1:0]     memData;
  } memwb_t;

endpackage

`default_nettype wire

// File: rtl/dmem_access_fsm.sv
// +----------------------------------------------------------------------------+
// | dmem_access_fsm : request/acknowledge sequencer for the data RAM, with an  |
// |                   optional watchdog enabled by MEM_TIMEOUT_EN.             |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_access_fsm
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_op_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic abort_o
`ifdef MEM_TIMEOUT_EN
  ,
  output logic timeout_o
`endif
);

  logic [0:0] r_state_q;
  logic [0:0] w_state_d;
  logic       w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= c_IDLE;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    case (r_state_q)
      c_IDLE: if (mem_op_i && !ack_i) w_state_d = c_WAIT;
      c_WAIT: if (!mem_op_i || ack_i || w_abort) w_state_d = c_IDLE;
      default: w_state_d = c_IDLE;
    endcase
  end

  // The request is held purely by the frozen EX/MEM register, so it is stable through WAIT.
  always_comb begin
    req_o   = mem_op_i;
    stall_o = mem_op_i & ~ack_i & ~w_abort;
    abort_o = w_abort;
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_cnt_q;
  logic       r_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_q     <= '0;
      r_timeout_q <= 1'b0;
    end else begin
      r_cnt_q     <= (r_state_q == c_WAIT) ? r_cnt_q + 8'd1 : 8'd0;
      r_timeout_q <= r_timeout_q | w_abort;
    end
  end

  // The IDLE request cycle counts as the first stalled cycle, hence the -1.
  assign w_abort   = (r_state_q == c_WAIT) && mem_op_i && !ack_i &&
                     (r_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign timeout_o = r_timeout_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_abort          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// +----------------------------------------------------------------------------+
// | mem_access_stage : MEM stage - EX/MEM and MEM/WB registers, alignment      |
// |                    check and data-RAM access. Option: MEM_TIMEOUT_EN.      |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     ex_aluOutput,
  input  logic [DATA_W-1:0]     ex_writeDataToDataRAM,
  input  logic                  ex_valid,
  input  logic                  ex_memRead,
  input  logic                  ex_memWrite,
  input  logic                  ex_regWrite,
  input  logic                  ex_memToReg,
  input  logic [REG_ADDR_W-1:0] ex_writeReg,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  memStall,
  output logic [DATA_W-1:0]     mem_memoryData,
  output logic                  mem_memOutOrAluOutWriteBackToRegFile,
  output logic                  alignError,
  output logic                  wb_valid,
  output logic                  wb_regWrite,
  output logic                  wb_memToReg,
  output logic [REG_ADDR_W-1:0] wb_writeReg,
  output logic [DATA_W-1:0]     wb_aluOutput,
  output logic [DATA_W-1:0]     wb_memData
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                  memTimeout
`endif
);

  exmem_t r_exmem_q, w_exmem_d;
  memwb_t r_memwb_q, w_memwb_d;
  logic   r_align_err_q;

  logic w_is_mem;
  logic w_aligned;
  logic w_mem_op;
  logic w_misalign;
  logic w_done;
  logic w_stall;
  logic w_abort;

  assign w_is_mem   = r_exmem_q.valid & (r_exmem_q.memRead | r_exmem_q.memWrite);
  assign w_aligned  = (r_exmem_q.alu[1:0] == 2'b00);
  assign w_mem_op   = w_is_mem & w_aligned;
  assign w_misalign = w_is_mem & ~w_aligned;
  assign w_done     = w_mem_op & dmem_ack;

  dmem_access_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_op_i  (w_mem_op),
    .ack_i     (dmem_ack),
    .req_o     (dmem_req),
    .stall_o   (w_stall),
    .abort_o   (w_abort)
`ifdef MEM_TIMEOUT_EN
    ,
    .timeout_o (memTimeout)
`endif
  );

  always_comb begin
    w_exmem_d = r_exmem_q;
    if (!w_stall) begin
      w_exmem_d.valid    = ex_valid;
      w_exmem_d.memRead  = ex_memRead;
      w_exmem_d.memWrite = ex_memWrite;
      w_exmem_d.regWrite = ex_regWrite;
      w_exmem_d.memToReg = ex_memToReg;
      w_exmem_d.writeReg = ex_writeReg;
      w_exmem_d.alu      = ex_aluOutput;
      w_exmem_d.wdata    = ex_writeDataToDataRAM;
    end
  end

  // While stalled WB sees a bubble; data fields simply keep their last value.
  always_comb begin
    w_memwb_d = r_memwb_q;
    if (w_stall) begin
      w_memwb_d.valid    = 1'b0;
      w_memwb_d.regWrite = 1'b0;
    end else begin
      w_memwb_d.valid     = r_exmem_q.valid;
      w_memwb_d.regWrite  = r_exmem_q.regWrite & ~w_misalign & ~w_abort;
      w_memwb_d.memToReg  = r_exmem_q.memToReg;
      w_memwb_d.writeReg  = r_exmem_q.writeReg;
      w_memwb_d.aluOutput = r_exmem_q.alu;
      w_memwb_d.memData   = w_done ? dmem_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmem_q     <= '0;
      r_memwb_q     <= '0;
      r_align_err_q <= 1'b0;
    end else begin
      r_exmem_q     <= w_exmem_d;
      r_memwb_q     <= w_memwb_d;
      r_align_err_q <= r_align_err_q | w_misalign;
    end
  end

  assign dmem_we    = w_mem_op & r_exmem_q.memWrite;
  assign dmem_addr  = r_exmem_q.alu[ADDR_W-1:0];
  assign dmem_wdata = r_exmem_q.wdata;
  assign memStall   = w_stall;

  assign mem_memoryData                       = dmem_rdata;
  assign mem_memOutOrAluOutWriteBackToRegFile = r_exmem_q.valid & r_exmem_q.memToReg;
  assign alignError                           = r_align_err_q;

  assign wb_valid     = r_memwb_q.valid;
  assign wb_regWrite  = r_memwb_q.regWrite;
  assign wb_memToReg  = r_memwb_q.memToReg;
  assign wb_writeReg  = r_memwb_q.writeReg;
  assign wb_aluOutput = r_memwb_q.aluOutput;
  assign wb_memData   = r_memwb_q.memData;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// +----------------------------------------------------------------------------+
// | tb_mem_access_stage : directed bench for the MEM stage with a behavioural  |
// |                       reference model and a variable-latency RAM responder.|
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ex_aluOutput = '0, ex_writeDataToDataRAM = '0;
  logic        ex_valid = 1'b0, ex_memRead = 1'b0, ex_memWrite = 1'b0;
  logic        ex_regWrite = 1'b0, ex_memToReg = 1'b0;
  logic [4:0]  ex_writeReg = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        memStall, alignError, mem_fwd;
  logic [31:0] mem_memoryData;
  logic        wb_valid, wb_regWrite, wb_memToReg;
  logic [4:0]  wb_writeReg;
  logic [31:0] wb_aluOutput, wb_memData;
`ifdef MEM_TIMEOUT_EN
  logic        memTimeout;
`endif

  mem_access_stage dut (
    .clk                                  (clk),
    .rst_n                                (rst_n),
    .ex_aluOutput                         (ex_aluOutput),
    .ex_writeDataToDataRAM                (ex_writeDataToDataRAM),
    .ex_valid                             (ex_valid),
    .ex_memRead                           (ex_memRead),
    .ex_memWrite                          (ex_memWrite),
    .ex_regWrite                          (ex_regWrite),
    .ex_memToReg                          (ex_memToReg),
    .ex_writeReg                          (ex_writeReg),
    .dmem_req                             (dmem_req),
    .dmem_we                              (dmem_we),
    .dmem_addr                            (dmem_addr),
    .dmem_wdata                           (dmem_wdata),
    .dmem_ack                             (dmem_ack),
    .dmem_rdata                           (dmem_rdata),
    .memStall                             (memStall),
    .mem_memoryData                       (mem_memoryData),
    .mem_memOutOrAluOutWriteBackToRegFile (mem_fwd),
    .alignError                           (alignError),
    .wb_valid                             (wb_valid),
    .wb_regWrite                          (wb_regWrite),
    .wb_memToReg                          (wb_memToReg),
    .wb_writeReg                          (wb_writeReg),
    .wb_aluOutput                         (wb_aluOutput),
    .wb_memData                           (wb_memData)
`ifdef MEM_TIMEOUT_EN
    ,
    .memTimeout                           (memTimeout)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- RAM responder ----------------
  logic [31:0] mem [64];
  int          waited = 0;
  int          cyc = 0;

  function automatic int lat_of(input logic [31:0] a);
    case (a)
      32'h10: return 0;
      32'h20: return 3;
      32'h30: return 1;
      32'h34: return 0;
      32'h14: return 2;
      32'h18: return 0;
      32'h40: return 1000;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    #2;
    cyc++;
    if (!rst_n || !dmem_req) begin
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_0000 | 32'(cyc);
      waited     = 0;
    end else if (waited >= lat_of(dmem_addr)) begin
      dmem_ack   = 1'b1;
      dmem_rdata = mem[dmem_addr[7:2]];
      if (dmem_we) mem[dmem_addr[7:2]] = dmem_wdata;
      waited     = 0;
    end else begin
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_0000 | 32'(cyc);
      waited++;
    end
  end

  // ---------------- Behavioural model: instruction in MEM, instruction in WB ----------------
  logic        m_v = 0, m_rd = 0, m_wr = 0, m_rw = 0, m_m2r = 0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_alu = '0, m_wd = '0;
  logic        w_v = 0, w_rw = 0, w_m2r = 0, m_err = 0;
  logic [4:0]  w_reg = '0;
  logic [31:0] w_alu = '0, w_md = '0;

  wire mdl_is_mem = m_v & (m_rd | m_wr);
  wire mdl_op     = mdl_is_mem & (m_alu % 4 == 0);
  wire mdl_mis    = mdl_is_mem & (m_alu % 4 != 0);
  wire mdl_stall  = mdl_op & ~dmem_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 0; m_rd <= 0; m_wr <= 0; m_rw <= 0; m_m2r <= 0; m_reg <= '0; m_alu <= '0; m_wd <= '0;
      w_v <= 0; w_rw <= 0; w_m2r <= 0; w_reg <= '0; w_alu <= '0; w_md <= '0; m_err <= 0;
    end else begin
      if (mdl_mis) m_err <= 1'b1;
      if (mdl_stall) begin
        w_v  <= 1'b0;
        w_rw <= 1'b0;
      end else begin
        w_v   <= m_v;
        w_rw  <= m_rw & ~mdl_mis;
        w_m2r <= m_m2r;
        w_reg <= m_reg;
        w_alu <= m_alu;
        w_md  <= (mdl_op && dmem_ack) ? dmem_rdata : 32'h0;
        m_v <= ex_valid; m_rd <= ex_memRead; m_wr <= ex_memWrite; m_rw <= ex_regWrite;
        m_m2r <= ex_memToReg; m_reg <= ex_writeReg; m_alu <= ex_aluOutput; m_wd <= ex_writeDataToDataRAM;
      end
    end
  end

  // ---------------- Compare process and event recording ----------------
  typedef struct { logic rw; logic [4:0] wr; logic [31:0] alu; logic [31:0] md; } wb_rec_t;
  wb_rec_t     wb_log[$];
  int          req_stalls[$];
  logic [31:0] fwd_q[$];
  int          stall_run = 0;

  always @(negedge clk) begin
    chk("dmem_req", dmem_req, mdl_op);
    chk("dmem_we", dmem_we, mdl_op & m_wr);
    if (mdl_op) begin
      chk("dmem_addr", dmem_addr, m_alu);
      chk("dmem_wdata", dmem_wdata, m_wd);
    end
    chk("memStall", memStall, mdl_stall);
    chk("mem_memoryData", mem_memoryData, dmem_rdata);
    chk("fwd_flag", mem_fwd, m_v & m_m2r);
    chk("alignError", alignError, m_err);
    chk("wb_valid", wb_valid, w_v);
    chk("wb_regWrite", wb_regWrite, w_rw);
    chk("wb_memToReg", wb_memToReg, w_m2r);
    chk("wb_writeReg", wb_writeReg, w_reg);
    chk("wb_aluOutput", wb_aluOutput, w_alu);
    chk("wb_memData", wb_memData, w_md);
    if (!rst_n) begin
      stall_run = 0;
    end else begin
      if (memStall) stall_run++;
      if (dmem_req && dmem_ack) begin
        req_stalls.push_back(stall_run);
        stall_run = 0;
      end
      if (mem_fwd && dmem_ack) fwd_q.push_back(mem_memoryData);
      if (wb_valid) wb_log.push_back('{wb_regWrite, wb_writeReg, wb_aluOutput, wb_memData});
    end
  end

  // Called at posedge+1; returns at the posedge+1 after the instruction entered MEM.
  task automatic issue(input logic v, input logic rd, input logic wr, input logic rw,
                       input logic m2r, input logic [4:0] rg, input logic [31:0] alu,
                       input logic [31:0] wd);
    int n;
    ex_valid = v; ex_memRead = rd; ex_memWrite = wr; ex_regWrite = rw;
    ex_memToReg = m2r; ex_writeReg = rg; ex_aluOutput = alu; ex_writeDataToDataRAM = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (memStall && n < 50);
    if (n >= 50) chk("stall_bound", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    issue(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[4] = 32'hDEADBEEF;
    mem[5] = 32'h0BADF00D;
    mem[6] = 32'h600DCAFE;
    mem[12] = 32'hCAFEF00D;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_dmem_req", dmem_req, 1'b0);
    chk("reset_alignError", alignError, 1'b0);
    rst_n = 1'b1;

    issue(1, 1, 0, 1, 1, 5'd5, 32'h10, 32'h0);               // lw x5, zero wait
    issue(1, 0, 1, 0, 0, 5'd0, 32'h20, 32'h12345678);        // sw, 3 waits
    issue(1, 1, 0, 1, 1, 5'd7, 32'h30, 32'h0);               // lw x7, 1 wait
    issue(1, 0, 1, 0, 0, 5'd0, 32'h34, 32'hCAFEF00D);        // sw x7 (forwarded value)
    issue(1, 0, 0, 1, 0, 5'd9, 32'hAAAA5555, 32'h0);         // ALU op, low bits nonzero
    issue(1, 1, 0, 1, 1, 5'd10, 32'h22, 32'h0);              // misaligned lw
    issue(1, 1, 0, 1, 1, 5'd11, 32'h14, 32'h0);              // lw x11, 2 waits
    repeat (4) bubble();

    chk("n_requests", 32'(req_stalls.size()), 32'd5);
    chk("stall_lw_zero_wait", 32'(req_stalls[0]), 32'd0);
    chk("stall_sw_3wait", 32'(req_stalls[1]), 32'd3);
    chk("stall_lw_1wait", 32'(req_stalls[2]), 32'd1);
    chk("stall_sw_b2b", 32'(req_stalls[3]), 32'd0);
    chk("stall_lw_2wait", 32'(req_stalls[4]), 32'd2);
    chk("n_retired", 32'(wb_log.size()), 32'd7);
    chk("lw0_memData", wb_log[0].md, 32'hDEADBEEF);
    chk("lw0_regWrite", wb_log[0].rw, 1'b1);
    chk("lw0_writeReg", wb_log[0].wr, 5'd5);
    chk("sw_regWrite", wb_log[1].rw, 1'b0);
    chk("lw7_memData", wb_log[2].md, 32'hCAFEF00D);
    chk("alu_value", wb_log[4].alu, 32'hAAAA5555);
    chk("alu_memData", wb_log[4].md, 32'h0);
    chk("misaligned_regWrite", wb_log[5].rw, 1'b0);
    chk("misaligned_writeReg", wb_log[5].wr, 5'd10);
    chk("lw11_memData", wb_log[6].md, 32'h0BADF00D);
    chk("lw11_regWrite", wb_log[6].rw, 1'b1);
    chk("fwd_loaded_value", fwd_q[1], 32'hCAFEF00D);
    chk("ram_sw_0x20", mem[8], 32'h12345678);
    chk("ram_sw_0x34", mem[13], 32'hCAFEF00D);
    chk("alignError_sticky", alignError, 1'b1);

    // Reset while an access is outstanding.
    ex_valid = 1; ex_memRead = 1; ex_memWrite = 0; ex_regWrite = 1;
    ex_memToReg = 1; ex_writeReg = 5'd12; ex_aluOutput = 32'h40; ex_writeDataToDataRAM = 0;
    repeat (3) @(posedge clk);
    #4;
    chk("wait_req_before_reset", dmem_req, 1'b1);
    chk("wait_stall_before_reset", memStall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", dmem_req, 1'b0);
    chk("rst_stall_drop", memStall, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_aluOutput", wb_aluOutput, 32'h0);
    chk("rst_wb_memData", wb_memData, 32'h0);
    chk("rst_alignError", alignError, 1'b0);
    ex_valid = 0; ex_memRead = 0; ex_regWrite = 0; ex_memToReg = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(1, 1, 0, 1, 1, 5'd13, 32'h18, 32'h0);
    repeat (3) bubble();
    chk("post_reset_retired", 32'(wb_log.size()), 32'd8);
    chk("post_reset_memData", wb_log[7].md, 32'h600DCAFE);
    chk("post_reset_writeReg", wb_log[7].wr, 5'd13);
    chk("post_reset_regWrite", wb_log[7].rw, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline; consumes EX outputs (ALU result, store data, control bits) and drives the WB stage.
- Contains the EX/MEM pipeline register, a request/acknowledge access FSM to a variable-latency data RAM, and the MEM/WB pipeline register.
- Stalls the pipeline while an access is outstanding.
- Returns load data and the load-pending flag to EX for the lw→sw store-data forwarding path.

Parameters:
- ADDR_W, 32, data-RAM byte address width; dmem_addr = M_alu[ADDR_W-1:0].
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_aluOutput  in  32  EX ALU result; memory address or writeback value.
- ex_writeDataToDataRAM  in  32  store data, already forwarded in EX.
- ex_valid  in  1  EX holds a real instruction.
- ex_memRead / ex_memWrite  in  1 each  load / store.
- ex_regWrite  in  1  instruction writes the register file.
- ex_memToReg  in  1  writeback selects memory data.
- ex_writeReg  in  5  destination register.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_W  word-aligned byte address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle.
- dmem_rdata  in  32  load data.
- memStall  out  1  freeze IF/ID/EX and the EX/MEM register.
- mem_memoryData  out  32  equals dmem_rdata; forwarded to EX.
- mem_memOutOrAluOutWriteBackToRegFile  out  1  M_valid & M_memToReg.
- alignError  out  1  sticky misaligned-access flag.
- wb_valid, wb_regWrite, wb_memToReg  out  1 each  MEM/WB control.
- wb_writeReg  out  5  MEM/WB destination register.
- wb_aluOutput, wb_memData  out  32 each  MEM/WB data.

Behaviour:
- Reset (async, rst_n=0): all EX/MEM and MEM/WB fields 0, FSM state IDLE, alignError=0. Consequently all outputs are 0 except mem_memoryData, which follows dmem_rdata.
- EX/MEM register (M_*):
  - Loads every ex_* input on a clk edge when memStall=0.
  - Holds its value when memStall=1.
- Pending memory op: memOp = M_valid & (M_memRead | M_memWrite) & aligned, where aligned = (M_alu[1:0]==0).
- FSM states IDLE and WAIT:
  - IDLE, memOp=1: dmem_req=1, dmem_we=M_memWrite. ack=1 → stay IDLE (single-cycle access). ack=0 → go to WAIT.
  - WAIT: dmem_req, dmem_addr, dmem_wdata and dmem_we held stable. ack=1 → IDLE.
  - dmem_req=0 whenever memOp=0. dmem_ack is ignored when dmem_req=0.
- memStall = memOp & ~dmem_ack; the stage is combinational from state and ack. Zero-wait access therefore causes no stall.
- Misaligned load/store (M_valid, memRead|memWrite, M_alu[1:0]!=0):
  - No request issued.
  - alignError set and held until reset.
  - Instruction proceeds with regWrite forced to 0 in MEM/WB.
- MEM/WB register:
  - memStall=0: loads M_* fields, with wb_memData = dmem_rdata if the access completed this cycle, else 0.
  - memStall=1: wb_valid=0 and wb_regWrite=0 (bubble); data fields don't-care but held.
- Back-to-back loads/stores: the next op is requested the cycle after the previous ack. No dead cycle is required beyond the register transfer.
- Reset mid-WAIT: the FSM returns to IDLE immediately and dmem_req drops asynchronously. The outstanding ack is abandoned.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter increments each WAIT cycle and clears in IDLE.
  - On reaching TIMEOUT_CYCLES, the access is aborted: FSM → IDLE and stall released that cycle.
  - MEM/WB receives regWrite=0.
  - Output memTimeout (1 bit, sticky until reset) is added.
- Without the macro: no counter, no memTimeout port, and WAIT persists indefinitely.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - FSM state encoding: IDLE=1'b0, WAIT=1'b1.
  - REG_ADDR_W=5.
  - DATA_W=32.
  - The EX/MEM and MEM/WB field bundles as packed structs.
- One sub-module, dmem_access_fsm: state register, request/hold logic and timeout counter. The top level keeps the two pipeline registers and alignment check.

Test Plan:
- Zero-wait lw: lw to addr 0x10, RAM acks same cycle with 0xDEADBEEF → memStall never 1; next edge wb_memData=0xDEADBEEF, wb_regWrite=1, wb_writeReg as issued.
- 3-wait sw: sw 0x12345678 to 0x20, ack after 3 cycles → memStall=1 for 3 cycles, dmem_addr/wdata stable, dmem_we=1; WB sees 3 bubbles (wb_valid=0), then the store with wb_regWrite=0.
- lw followed by sw of the same register: mem_memOutOrAluOutWriteBackToRegFile=1 during the lw's MEM cycle and mem_memoryData equals dmem_rdata → EX store data receives the loaded value.
- Misaligned lw at 0x22 → no dmem_req, alignError=1 persists, wb_regWrite=0; the following aligned lw completes normally.
- rst_n low during WAIT → dmem_req=0 immediately, all wb_* = 0, state IDLE; after release, a fresh lw completes.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → stall for exactly 4 cycles, then memTimeout=1, wb_regWrite=0, pipeline advances.
